// File: rtl/signal_lamp_ctrl.sv
// Multi-approach traffic lamp sequencer with latched pedestrian WALK interval.
// Optional LEFT_ARROW_EN inserts a protected left-turn interval before each GREEN.
//
// state  | meaning
// ALLRED | every approach red; decides WALK or next vehicle interval
// LEFT   | left arrow + green on active approach (LEFT_ARROW_EN only)
// GREEN  | green on active approach
// YELLOW | yellow on active approach; PHASE advances on exit
// WALK   | all vehicles red, pedestrian walk lamp on
module signal_lamp_ctrl #(
  parameter int NUM_PHASES   = 3,
  parameter int CNT_W        = 8,
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  parameter int PED_TICKS    = 6,
  parameter int LEFT_TICKS   = 3
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  ENABLE,
  input  logic                  TICK,
  input  logic                  PED_REQ,
  output logic [NUM_PHASES-1:0] G,
  output logic [NUM_PHASES-1:0] Y,
  output logic [NUM_PHASES-1:0] R,
  output logic [NUM_PHASES-1:0] L,
  output logic                  PED_G,
  output logic                  PED_R,
  output logic                  PED_WAIT,
  output logic [2:0]            PHASE,
  output logic [2:0]            STATE
);

  typedef enum logic [2:0] {
    ST_ALLRED = 3'd0,
    ST_LEFT   = 3'd1,
    ST_GREEN  = 3'd2,
    ST_YELLOW = 3'd3,
    ST_WALK   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0]      LD_GREEN  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0]      LD_YELLOW = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0]      LD_ALLRED = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0]      LD_WALK   = CNT_W'(PED_TICKS - 1);
  localparam logic [CNT_W-1:0]      LD_LEFT   = CNT_W'(LEFT_TICKS - 1);
  localparam logic [2:0]            LAST_PH   = 3'(NUM_PHASES - 1);
  localparam logic [NUM_PHASES-1:0] ONE_HOT0  = NUM_PHASES'(1);

`ifdef LEFT_ARROW_EN
  localparam state_t FIRST_GO = ST_LEFT;
`else
  localparam state_t FIRST_GO = ST_GREEN;
`endif

  state_t           state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ped_q;
  logic             step;
  logic             enter_walk;
  logic [NUM_PHASES-1:0] sel;

  function automatic logic [CNT_W-1:0] dur(input state_t s);
    logic [CNT_W-1:0] d;
    d = LD_ALLRED;
    case (s)
      ST_LEFT:   d = LD_LEFT;
      ST_GREEN:  d = LD_GREEN;
      ST_YELLOW: d = LD_YELLOW;
      ST_WALK:   d = LD_WALK;
      default:   d = LD_ALLRED;
    endcase
    return d;
  endfunction

  // ENABLE is active-low: frozen cycles drop the tick rather than buffering it
  assign step       = ~ENABLE & TICK;
  assign enter_walk = (state_d == ST_WALK) && (state_q != ST_WALK);

  always_ff @(negedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_ALLRED;
      phase_q <= 3'd0;
      cnt_q   <= LD_ALLRED;
      ped_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      ped_q   <= PED_REQ | (ped_q & ~enter_walk);
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (step) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        case (state_q)
          ST_ALLRED: state_d = ped_q ? ST_WALK : FIRST_GO;
          ST_LEFT:   state_d = ST_GREEN;
          ST_GREEN:  state_d = ST_YELLOW;
          ST_YELLOW: begin
            state_d = ST_ALLRED;
            phase_d = (phase_q == LAST_PH) ? 3'd0 : phase_q + 3'd1;
          end
          ST_WALK:   state_d = ST_ALLRED;
          default:   state_d = ST_ALLRED;
        endcase
        cnt_d = dur(state_d);
      end
    end
  end

  assign sel = ONE_HOT0 << phase_q;

  always_comb begin
    G = '0;
    Y = '0;
    L = '0;
    case (state_q)
      ST_GREEN:  G = sel;
      ST_YELLOW: Y = sel;
`ifdef LEFT_ARROW_EN
      ST_LEFT: begin
        G = sel;
        L = sel;
      end
`endif
      default: ;
    endcase
  end

  assign R        = ~(G | Y);
  assign PED_G    = (state_q == ST_WALK);
  assign PED_R    = ~PED_G;
  assign PED_WAIT = ped_q;
  assign PHASE    = phase_q;
  assign STATE    = state_q;

endmodule

// File: tb/tb_signal_lamp_ctrl.sv
// Directed table-driven bench for signal_lamp_ctrl at default parameters.
// Build with LEFT_ARROW_EN defined to exercise the left-arrow table instead.
module tb_signal_lamp_ctrl;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       tick;
  logic       ped_req;
  logic [2:0] g, y, r, l;
  logic       ped_g, ped_r, ped_wait;
  logic [2:0] phase, state;

  int n_chk;
  int n_err;

  typedef struct {
    logic       en, tk, pd;
    logic [2:0] st, ph, g, y, r, l;
    logic       pg, pw;
  } vec_t;

  vec_t vq[$];

  signal_lamp_ctrl dut (
    .CLK(clk), .RESET_N(rst_n), .ENABLE(enable), .TICK(tick), .PED_REQ(ped_req),
    .G(g), .Y(y), .R(r), .L(l),
    .PED_G(ped_g), .PED_R(ped_r), .PED_WAIT(ped_wait),
    .PHASE(phase), .STATE(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic en, input logic tk, input logic pd,
                              input logic [2:0] st, input logic [2:0] ph,
                              input logic [2:0] eg, input logic [2:0] ey,
                              input logic [2:0] er, input logic [2:0] el,
                              input logic pg, input logic pw, input int n);
    vec_t v;
    v.en = en; v.tk = tk; v.pd = pd;
    v.st = st; v.ph = ph; v.g = eg; v.y = ey; v.r = er; v.l = el;
    v.pg = pg; v.pw = pw;
    for (int k = 0; k < n; k++) vq.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [21:0] exp);
    logic [21:0] act;
    act = {state, phase, g, y, r, l, ped_g, ped_r, ped_wait};
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got st=%0d ph=%0d g=%b y=%b r=%b l=%b pg=%b pr=%b pw=%b, expected st=%0d ph=%0d g=%b y=%b r=%b l=%b pg=%b pr=%b pw=%b",
               nm, act[21:19], act[18:16], act[15:13], act[12:10], act[9:7], act[6:4],
               act[3], act[2], act[1], exp[21:19], exp[18:16], exp[15:13], exp[12:10],
               exp[9:7], exp[6:4], exp[3], exp[2], exp[1]);
    end
  endtask

  localparam logic [21:0] RESET_EXP = {3'd0, 3'd0, 3'b000, 3'b000, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0};
`ifdef LEFT_ARROW_EN
  localparam logic [21:0] FIRST_EXP = {3'd1, 3'd0, 3'b001, 3'b000, 3'b110, 3'b001, 1'b0, 1'b1, 1'b0};
`else
  localparam logic [21:0] FIRST_EXP = {3'd2, 3'd0, 3'b001, 3'b000, 3'b110, 3'b000, 1'b0, 1'b1, 1'b0};
`endif

  initial begin
    n_chk = 0;
    n_err = 0;

`ifdef LEFT_ARROW_EN
    add(0,1,0, 1,0, 3'b001,3'b000,3'b110,3'b001, 0,0, 3);
    add(0,1,0, 2,0, 3'b001,3'b000,3'b110,3'b000, 0,0, 8);
    add(0,1,0, 3,0, 3'b000,3'b001,3'b110,3'b000, 0,0, 2);
    add(0,1,0, 0,1, 3'b000,3'b000,3'b111,3'b000, 0,0, 1);
    add(0,1,0, 1,1, 3'b010,3'b000,3'b101,3'b010, 0,0, 3);
    add(0,1,0, 2,1, 3'b010,3'b000,3'b101,3'b000, 0,0, 8);
    add(0,1,0, 3,1, 3'b000,3'b010,3'b101,3'b000, 0,0, 1);
`else
    // three full phases and the wrap back to approach 0
    add(0,1,0, 2,0, 3'b001,3'b000,3'b110,3'b000, 0,0, 8);
    add(0,1,0, 3,0, 3'b000,3'b001,3'b110,3'b000, 0,0, 2);
    add(0,1,0, 0,1, 3'b000,3'b000,3'b111,3'b000, 0,0, 1);
    add(0,1,0, 2,1, 3'b010,3'b000,3'b101,3'b000, 0,0, 8);
    add(0,1,0, 3,1, 3'b000,3'b010,3'b101,3'b000, 0,0, 2);
    add(0,1,0, 0,2, 3'b000,3'b000,3'b111,3'b000, 0,0, 1);
    add(0,1,0, 2,2, 3'b100,3'b000,3'b011,3'b000, 0,0, 8);
    add(0,1,0, 3,2, 3'b000,3'b100,3'b011,3'b000, 0,0, 2);
    add(0,1,0, 0,0, 3'b000,3'b000,3'b111,3'b000, 0,0, 1);
    // pedestrian pulse during green of approach 0
    add(0,1,0, 2,0, 3'b001,3'b000,3'b110,3'b000, 0,0, 1);
    add(0,1,1, 2,0, 3'b001,3'b000,3'b110,3'b000, 0,1, 1);
    add(0,1,0, 2,0, 3'b001,3'b000,3'b110,3'b000, 0,1, 6);
    add(0,1,0, 3,0, 3'b000,3'b001,3'b110,3'b000, 0,1, 2);
    add(0,1,0, 0,1, 3'b000,3'b000,3'b111,3'b000, 0,1, 1);
    // request on the WALK-entry edge: set wins, served again after ALLRED
    add(0,1,1, 4,1, 3'b000,3'b000,3'b111,3'b000, 1,1, 1);
    add(0,1,0, 4,1, 3'b000,3'b000,3'b111,3'b000, 1,1, 5);
    add(0,1,0, 0,1, 3'b000,3'b000,3'b111,3'b000, 0,1, 1);
    add(0,1,0, 4,1, 3'b000,3'b000,3'b111,3'b000, 1,0, 6);
    add(0,1,0, 0,1, 3'b000,3'b000,3'b111,3'b000, 0,0, 1);
    // freeze mid-green for 20 cycles, request latched while frozen
    add(0,1,0, 2,1, 3'b010,3'b000,3'b101,3'b000, 0,0, 3);
    add(1,1,0, 2,1, 3'b010,3'b000,3'b101,3'b000, 0,0, 10);
    add(1,1,1, 2,1, 3'b010,3'b000,3'b101,3'b000, 0,1, 1);
    add(1,1,0, 2,1, 3'b010,3'b000,3'b101,3'b000, 0,1, 9);
    add(0,0,0, 2,1, 3'b010,3'b000,3'b101,3'b000, 0,1, 2);
    add(0,1,0, 2,1, 3'b010,3'b000,3'b101,3'b000, 0,1, 5);
    add(0,1,0, 3,1, 3'b000,3'b010,3'b101,3'b000, 0,1, 1);
`endif

    rst_n   = 1'b0;
    enable  = 1'b0;
    tick    = 1'b0;
    ped_req = 1'b0;
    repeat (2) @(posedge clk);
    check("reset", RESET_EXP);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      enable  = vq[i].en;
      tick    = vq[i].tk;
      ped_req = vq[i].pd;
      @(negedge clk);
      @(posedge clk);
      check($sformatf("vec%0d", i),
            {vq[i].st, vq[i].ph, vq[i].g, vq[i].y, vq[i].r, vq[i].l,
             vq[i].pg, ~vq[i].pg, vq[i].pw});
    end

    // asynchronous reset between edges, then held across an edge with TICK active
    enable  = 1'b0;
    tick    = 1'b1;
    ped_req = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_reset", RESET_EXP);
    @(negedge clk);
    @(posedge clk);
    check("reset_hold", RESET_EXP);
    rst_n = 1'b1;
    @(negedge clk);
    @(posedge clk);
    check("after_reset", FIRST_EXP);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
